// File: rtl/eth_pkt_fifo.sv
// Store-and-forward packet FIFO holding up to MAX_PKTS committed packets, each with a length descriptor.
// Latency: the first beat of a packet appears 2 cycles after its last input beat is accepted (idle reader).
// Backpressure: in_ready drops only between packets while every descriptor is in use; output is valid/ready.
//
// Ports:
//   clk, rst (async, active low), clear (synchronous flush, no drop pulse)
//   in_valid/in_ready/in_data/in_last/in_error : packet input, in_error sampled with in_last
//   out_valid/out_ready/out_data/out_last       : packet output, out_len = head packet length
//   pkt_count, used, empty, full                : occupancy status
//   done (last output beat taken), drop (packet discarded) : 1-cycle pulses
module eth_pkt_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 1024,
  parameter int MAX_PKTS = 4,
  parameter int LEN_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic                      in_error,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [LEN_W-1:0]          out_len,
  output logic [$clog2(MAX_PKTS):0] pkt_count,
  output logic [$clog2(DEPTH):0]    used,
  output logic                      empty,
  output logic                      full,
  output logic                      done,
  output logic                      drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int QW = $clog2(MAX_PKTS);
  localparam int CW = QW + 1;

  typedef enum logic [1:0] {W_IDLE, W_STREAM, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_STREAM, R_DONE} rstate_t;

  wstate_t wstate;
  rstate_t rstate;

  logic [DATA_W-1:0] mem      [DEPTH];
  logic [LEN_W-1:0]  desc_mem [MAX_PKTS];

  logic [PW-1:0]     wr_ptr, commit_ptr, rd_ptr;
  logic [QW-1:0]     dq_wr, dq_rd;
  logic [LEN_W-1:0]  wlen, len_next, beat_cnt, head_len;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_q;
  logic              run;
  logic              quiet;
  logic              desc_full, buf_full;
  logic              in_hs, out_hs, wr_store, commit, pop;

  assign desc_full = (pkt_count == CW'(MAX_PKTS));
  // Wrap bits differ and addresses match: every slot holds a beat not yet handed out.
  assign buf_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = run && ((wstate != W_IDLE) || !desc_full);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign wr_store  = in_hs && !clear && (wstate != W_DROP) && !buf_full;
  assign commit    = wr_store && in_last && !in_error;
  assign pop       = out_hs && out_last && !clear;
  assign len_next  = ((wstate == W_IDLE) ? '0 : wlen) + LEN_W'(1);
  assign head_len  = desc_mem[dq_rd];
  // rd_ptr only advances on a handshake, so the beat on the output still counts
  // as held; prefetch the following beat in the same cycle it is consumed.
  assign rd_addr   = out_hs ? (rd_ptr[AW-1:0] + AW'(1)) : rd_ptr[AW-1:0];
  assign out_data  = out_valid ? rd_q : '0;
  assign used      = wr_ptr - rd_ptr;
  assign empty     = (pkt_count == '0);
  assign full      = desc_full || (used == PW'(DEPTH));

  // Storage: data buffer, descriptor ring and registered read port.
  always_ff @(posedge clk) begin
    if (wr_store) mem[wr_ptr[AW-1:0]] <= in_data;
    if (commit)   desc_mem[dq_wr]     <= len_next;
    rd_q <= mem[rd_addr];
  end

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  // Write FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate     <= W_IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      dq_wr      <= '0;
      wlen       <= '0;
      quiet      <= 1'b0;
      drop       <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (clear) begin
        wr_ptr     <= '0;
        commit_ptr <= '0;
        dq_wr      <= '0;
        wlen       <= '0;
        // The tail of a packet cut by clear is swallowed silently; a last beat
        // taken in the clear cycle closes the packet instead.
        quiet      <= 1'b1;
        if (((wstate != W_IDLE) || in_hs) && !(in_hs && in_last)) wstate <= W_DROP;
        else                                                        wstate <= W_IDLE;
      end else begin
        case (wstate)
          W_IDLE, W_STREAM: begin
            if (in_hs) begin
              if (buf_full) begin
                wr_ptr <= commit_ptr;
                wlen   <= '0;
                quiet  <= 1'b0;
                if (in_last) begin
                  drop   <= 1'b1;
                  wstate <= W_IDLE;
                end else begin
                  wstate <= W_DROP;
                end
              end else if (in_last) begin
                wlen   <= '0;
                wstate <= W_IDLE;
                if (in_error) begin
                  wr_ptr <= commit_ptr;
                  drop   <= 1'b1;
                end else begin
                  wr_ptr     <= wr_ptr + PW'(1);
                  commit_ptr <= wr_ptr + PW'(1);
                  dq_wr      <= dq_wr + QW'(1);
                end
              end else begin
                wr_ptr <= wr_ptr + PW'(1);
                wlen   <= len_next;
                wstate <= W_STREAM;
              end
            end
          end
          W_DROP: begin
            if (in_hs && in_last) begin
              drop   <= !quiet;
              quiet  <= 1'b0;
              wstate <= W_IDLE;
            end
          end
          default: wstate <= W_IDLE;
        endcase
      end
    end
  end

  // Read FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate    <= R_IDLE;
      rd_ptr    <= '0;
      dq_rd     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_len   <= '0;
      beat_cnt  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        rstate    <= R_IDLE;
        rd_ptr    <= '0;
        dq_rd     <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_len   <= '0;
        beat_cnt  <= '0;
      end else begin
        case (rstate)
          // R_DONE is the one-cycle gap that lets rd_q reload from the new rd_ptr.
          R_IDLE, R_DONE: begin
            if (!empty) begin
              rstate    <= R_STREAM;
              out_valid <= 1'b1;
              out_len   <= head_len;
              out_last  <= (head_len == LEN_W'(1));
              beat_cnt  <= '0;
            end else begin
              rstate <= R_IDLE;
            end
          end
          R_STREAM: begin
            if (out_ready) begin
              rd_ptr <= rd_ptr + PW'(1);
              if (out_last) begin
                done      <= 1'b1;
                dq_rd     <= dq_rd + QW'(1);
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                rstate    <= R_DONE;
              end else begin
                beat_cnt <= beat_cnt + LEN_W'(1);
                out_last <= ((beat_cnt + LEN_W'(2)) == out_len);
              end
            end
          end
          default: rstate <= R_IDLE;
        endcase
      end
    end
  end

  // Committed-packet count; commit and pop in the same cycle cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  pkt_count <= '0;
    else if (clear)            pkt_count <= '0;
    else if (commit && !pop)   pkt_count <= pkt_count + CW'(1);
    else if (pop && !commit)   pkt_count <= pkt_count - CW'(1);
  end

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Directed bench for eth_pkt_fifo with a beat scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// out_ready is driven per cycle as always-low, always-high or random.
module tb_eth_pkt_fifo;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 1024;
  localparam int MAX_PKTS = 4;
  localparam int LEN_W    = 16;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_error;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [LEN_W-1:0]  out_len;
  logic [2:0]        pkt_count;
  logic [10:0]       used;
  logic              empty;
  logic              full;
  logic              done;
  logic              drop;

  eth_pkt_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_PKTS(MAX_PKTS), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_error(in_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_len(out_len),
    .pkt_count(pkt_count), .used(used), .empty(empty), .full(full),
    .done(done), .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] len;
    logic        last;
    logic [7:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_done = 0;
  int          n_drop = 0;
  int          rdy_mode = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  dat_prev = '0;
  int          d0;
  int          p0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: choose out_ready, score any output handshake, advance.
  task automatic cyc();
    exp_t e;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
    if (stall_prev) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, dat_prev);
    end
    if (out_valid && out_ready) begin
      check("sb_has_beat", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_last", out_last, e.last);
        check("out_len", out_len, e.len);
      end
    end
    stall_prev = out_valid && !out_ready && !clear;
    dat_prev   = out_data;
    @(posedge clk);
    #1;
    if (done) n_done++;
    if (drop) n_drop++;
  endtask

  // Beats [from, to) of a packet of length len, data = base + index.
  task automatic send_part(input int len, input int base, input int from, input int to, input bit err);
    for (int i = from; i < to; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(base + i);
      in_last  = (i == len - 1);
      in_error = err && (i == len - 1);
      for (int w = 0; w < 3000 && !in_ready; w++) cyc();
      check("in_ready_wait", in_ready, 1'b1);
      cyc();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_error = 1'b0;
    in_data  = '0;
  endtask

  task automatic push_pkt(input int len, input int base);
    for (int i = 0; i < len; i++)
      exp_q.push_back('{len: 16'(len), last: (i == len - 1), data: 8'(base + i)});
  endtask

  task automatic drain(input int limit);
    for (int w = 0; w < limit && exp_q.size() != 0; w++) cyc();
    check("drained", exp_q.size(), 0);
    cyc();
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; in_error = 1'b0; out_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_len", out_len, 16'h0);
    check("rst_done", done, 1'b0);
    check("rst_drop", drop, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_pkt_count", pkt_count, 3'd0);
    check("rst_used", used, 11'd0);
    rst = 1'b1;
    #1;
    check("in_ready_before_clk", in_ready, 1'b0);
    cyc();
    check("in_ready_after_clk", in_ready, 1'b1);

    // Single 64-beat packet, sink always ready
    rdy_mode = 1;
    d0 = n_done;
    send_part(64, 0, 0, 64, 1'b0);
    push_pkt(64, 0);
    check("t1_valid_plus1", out_valid, 1'b0);
    check("t1_pkt_count", pkt_count, 3'd1);
    check("t1_used", used, 11'd64);
    cyc();
    check("t1_valid_plus2", out_valid, 1'b1);
    check("t1_len", out_len, 16'd64);
    check("t1_first_data", out_data, 8'h00);
    drain(200);
    check("t1_done_cnt", n_done - d0, 1);
    check("t1_empty", empty, 1'b1);
    check("t1_used_end", used, 11'd0);

    // Four 10-beat packets fill the descriptor ring
    rdy_mode = 0;
    d0 = n_done;
    for (int k = 0; k < 4; k++) begin
      send_part(10, 16 * k, 0, 10, 1'b0);
      push_pkt(10, 16 * k);
    end
    check("t2_pkt_count", pkt_count, 3'd4);
    check("t2_full", full, 1'b1);
    check("t2_used", used, 11'd40);
    in_valid = 1'b1; in_data = 8'h77;
    cyc();
    check("t2_in_ready_blocked", in_ready, 1'b0);
    cyc();
    check("t2_in_ready_blocked2", in_ready, 1'b0);
    check("t2_pkt_count_hold", pkt_count, 3'd4);
    in_valid = 1'b0; in_data = '0;
    rdy_mode = 1;
    for (int w = 0; w < 100 && !in_ready; w++) cyc();
    check("t2_in_ready_back", in_ready, 1'b1);
    check("t2_done_at_ready", n_done - d0, 1);
    check("t2_pkt_count_3", pkt_count, 3'd3);
    drain(200);
    check("t2_done_cnt", n_done - d0, 4);
    check("t2_empty", empty, 1'b1);

    // Errored 20-beat packet, then a good 5-beat packet
    rdy_mode = 0;
    p0 = n_drop;
    d0 = n_done;
    send_part(20, 8'h80, 0, 20, 1'b1);
    check("t3_drop", n_drop - p0, 1);
    check("t3_used_after_drop", used, 11'd0);
    check("t3_pkt_after_drop", pkt_count, 3'd0);
    send_part(5, 8'h30, 0, 5, 1'b0);
    push_pkt(5, 8'h30);
    check("t3_used", used, 11'd5);
    check("t3_pkt_count", pkt_count, 3'd1);
    rdy_mode = 1;
    drain(100);
    check("t3_done_cnt", n_done - d0, 1);
    check("t3_drop_total", n_drop - p0, 1);

    // Buffer overflow: 1000-beat packet held, 100-beat packet overflows
    rdy_mode = 0;
    p0 = n_drop;
    d0 = n_done;
    send_part(1000, 0, 0, 1000, 1'b0);
    push_pkt(1000, 0);
    check("t4_used_1000", used, 11'd1000);
    check("t4_full_no", full, 1'b0);
    send_part(100, 8'h55, 0, 24, 1'b0);
    check("t4_used_full", used, 11'd1024);
    check("t4_full", full, 1'b1);
    send_part(100, 8'h55, 24, 25, 1'b0);
    check("t4_used_rewound", used, 11'd1000);
    check("t4_full_clear", full, 1'b0);
    check("t4_no_drop_yet", n_drop - p0, 0);
    send_part(100, 8'h55, 25, 100, 1'b0);
    check("t4_drop", n_drop - p0, 1);
    check("t4_used_end_in", used, 11'd1000);
    check("t4_pkt_count", pkt_count, 3'd1);
    rdy_mode = 1;
    drain(3000);
    check("t4_done_cnt", n_done - d0, 1);
    check("t4_empty", empty, 1'b1);

    // Pointer wrap: 300 packets of 7 beats with random sink stalls
    rdy_mode = 2;
    d0 = n_done;
    for (int k = 0; k < 300; k++) begin
      send_part(7, 7 * k, 0, 7, 1'b0);
      push_pkt(7, 7 * k);
    end
    drain(20000);
    check("t5_done_cnt", n_done - d0, 300);
    check("t5_used", used, 11'd0);
    check("t5_empty", empty, 1'b1);

    // clear mid-output and mid-input
    rdy_mode = 0;
    p0 = n_drop;
    d0 = n_done;
    send_part(6, 8'hC0, 0, 6, 1'b0);
    cyc();
    check("t6_out_valid_pre", out_valid, 1'b1);
    send_part(8, 8'hA0, 0, 3, 1'b0);
    check("t6_used_pre", used, 11'd9);
    in_valid = 1'b1; in_data = 8'hA3; in_last = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    in_valid = 1'b0; in_data = '0;
    check("t6_out_valid_clr", out_valid, 1'b0);
    check("t6_used_clr", used, 11'd0);
    check("t6_pkt_clr", pkt_count, 3'd0);
    check("t6_empty_clr", empty, 1'b1);
    send_part(8, 8'hA0, 4, 8, 1'b0);
    check("t6_no_drop", n_drop - p0, 0);
    check("t6_used_tail", used, 11'd0);
    check("t6_out_valid_tail", out_valid, 1'b0);
    rdy_mode = 1;
    send_part(5, 8'hE0, 0, 5, 1'b0);
    push_pkt(5, 8'hE0);
    drain(100);
    check("t6_done_cnt", n_done - d0, 1);
    check("t6_empty_end", empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
